// File: rtl/mem_stage.sv
// RV32I memory stage: load/store over a req/gnt/rvalid data port, non-memory ops registered to writeback.
// Optional feature macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of ignoring the low address bits.
module mem_stage #(
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstl,
  input  logic        valid_exe_2_mem_i,
  output logic        ready_mem_2_exe_o,
  input  logic [31:0] opcode_exe_2_mem_i,
  input  logic [10:0] rd_exe_2_mem_i,
  input  logic [31:0] rd_data_exe_2_mem_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_data_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [10:0] wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        bus_err_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] CNT_LAST = 8'(RSP_TIMEOUT - 1);

  // Access size encoding is funct3[1:0]: 00 byte, 01 half, 1x word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        discard_q, discard_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [10:0] rd_q, rd_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        wb_valid_q, wb_valid_d;
  logic [10:0] wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        bus_err_q, bus_err_d;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;
  logic        misaligned;
`endif

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_load, is_store, is_mem, accept;
  logic [1:0]  a_raw, a_eff;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shifted, ld_data;

  logic unused_opcode_hi;
  assign unused_opcode_hi = ^opcode_exe_2_mem_i[31:10];

  assign opc      = opcode_exe_2_mem_i[6:0];
  assign f3       = opcode_exe_2_mem_i[9:7];
  assign is_load  = (opc == OP_LOAD);
  assign is_store = (opc == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign accept   = valid_exe_2_mem_i & ready_mem_2_exe_o & ~flush_i;
  assign a_raw    = mem_address_i[1:0];

  // NOTE: every always_comb output gets a default before any branch; a missed path would otherwise infer a latch.
  always_comb begin
    a_eff    = 2'b00;
    st_be    = 4'b1111;
    st_wdata = mem_data_i;
    case (f3[1:0])
      SZ_B: begin
        a_eff    = a_raw;
        st_be    = 4'b0001 << a_raw;
        st_wdata = {4{mem_data_i[7:0]}};
      end
      SZ_H: begin
        a_eff    = {a_raw[1], 1'b0};
        st_be    = a_raw[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (f3[1:0] == SZ_H)  misaligned = a_raw[0];
    else if (f3[1])       misaligned = |a_raw;
  end
`endif

  // Load extraction works from the offset and size latched at accept time.
  always_comb begin
    ld_shifted = dmem_rdata_i >> {ld_off_q, 3'b000};
    ld_data    = dmem_rdata_i;
    case (ld_size_q)
      SZ_B:    ld_data = {{24{~ld_uns_q & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = {{16{~ld_uns_q & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    ld_size_d  = ld_size_q;
    ld_uns_d   = ld_uns_q;
    ld_off_d   = ld_off_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    bus_err_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = (rd_exe_2_mem_i[4:0] != 5'd0);
            wb_rd_d    = rd_exe_2_mem_i;
            wb_data_d  = rd_data_exe_2_mem_i;
          end
`ifdef MISALIGN_TRAP_EN
          else if (misaligned) begin
            misalign_d      = 1'b1;
            misalign_addr_d = mem_address_i;
          end
`endif
          else begin
            state_d   = S_REQ;
            discard_d = 1'b0;
            we_d      = is_store;
            be_d      = st_be;
            addr_d    = {mem_address_i[31:2], 2'b00};
            wdata_d   = st_wdata;
            rd_d      = rd_exe_2_mem_i;
            ld_size_d = f3[1:0];
            ld_uns_d  = f3[2];
            ld_off_d  = a_eff;
          end
        end
      end
      S_REQ: begin
        // A grant in the flush cycle still counts: the access has left the stage.
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_WAIT_RSP;
            cnt_d     = 8'd0;
            discard_d = flush_i;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RSP: begin
        if (flush_i) discard_d = 1'b1;
        if (dmem_rvalid_i) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          if (!discard_q && !flush_i) begin
            wb_valid_d = (rd_q[4:0] != 5'd0);
            wb_rd_d    = rd_q;
            wb_data_d  = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = 8'd0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstl) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      discard_q  <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 11'd0;
      ld_size_q  <= 2'b00;
      ld_uns_q   <= 1'b0;
      ld_off_q   <= 2'b00;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 11'd0;
      wb_data_q  <= 32'd0;
      bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      ld_size_q  <= ld_size_d;
      ld_uns_q   <= ld_uns_d;
      ld_off_q   <= ld_off_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      bus_err_q  <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
`endif
    end
  end

  assign ready_mem_2_exe_o = (state_q == S_IDLE);
  assign dmem_req_o        = (state_q == S_REQ);
  assign dmem_we_o         = we_q;
  assign dmem_be_o         = be_q;
  assign dmem_addr_o       = addr_q;
  assign dmem_wdata_o      = wdata_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_rd_o           = wb_rd_q;
  assign wb_data_o         = wb_data_q;
  assign bus_err_o         = bus_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_o        = misalign_q;
  assign misalign_addr_o   = misalign_addr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected writebacks and memory requests are queued at stimulus time
// and compared by a negedge monitor when the DUT produces them.
module tb_mem_stage;

  localparam int TO = 12;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rstl = 1'b0;
  logic        valid_exe_2_mem_i = 1'b0;
  logic        ready_mem_2_exe_o;
  logic [31:0] opcode_exe_2_mem_i = '0;
  logic [10:0] rd_exe_2_mem_i = '0;
  logic [31:0] rd_data_exe_2_mem_i = '0;
  logic [31:0] mem_address_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        flush_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        wb_valid_o;
  logic [10:0] wb_rd_o;
  logic [31:0] wb_data_o;
  logic        bus_err_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  always #5 clk = ~clk;

  mem_stage #(.RSP_TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rstl                (rstl),
    .valid_exe_2_mem_i   (valid_exe_2_mem_i),
    .ready_mem_2_exe_o   (ready_mem_2_exe_o),
    .opcode_exe_2_mem_i  (opcode_exe_2_mem_i),
    .rd_exe_2_mem_i      (rd_exe_2_mem_i),
    .rd_data_exe_2_mem_i (rd_data_exe_2_mem_i),
    .mem_address_i       (mem_address_i),
    .mem_data_i          (mem_data_i),
    .flush_i             (flush_i),
    .dmem_req_o          (dmem_req_o),
    .dmem_we_o           (dmem_we_o),
    .dmem_be_o           (dmem_be_o),
    .dmem_addr_o         (dmem_addr_o),
    .dmem_wdata_o        (dmem_wdata_o),
    .dmem_gnt_i          (dmem_gnt_i),
    .dmem_rvalid_i       (dmem_rvalid_i),
    .dmem_rdata_i        (dmem_rdata_i),
    .wb_valid_o          (wb_valid_o),
    .wb_rd_o             (wb_rd_o),
    .wb_data_o           (wb_data_o),
    .bus_err_o           (bus_err_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o          (misalign_o),
    .misalign_addr_o     (misalign_addr_o)
`endif
  );

  typedef struct {
    logic [10:0] rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   bus_err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference lane model, written per byte rather than by shifting.
  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      case (f3[1:0])
        2'b00:   be[i] = (i == int'(a));
        2'b01:   be[i] = ((i / 2) == int'(a[1]));
        default: be[i] = 1'b1;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] lo, hi;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    case (f3[1:0])
      2'b00: begin
        lo = b[a];
        return f3[2] ? {24'h0, lo} : {{24{lo[7]}}, lo};
      end
      2'b01: begin
        lo = b[{a[1], 1'b0}];
        hi = b[{a[1], 1'b1}];
        return f3[2] ? {16'h0, hi, lo} : {{16{hi[7]}}, hi, lo};
      end
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    wb_t  e;
    req_t r;
    if (wb_valid_o) begin
      if (exp_wb.size() == 0) check("wb_unexpected", 32'(wb_valid_o), 0);
      else begin
        e = exp_wb.pop_front();
        check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
        check("wb_data", wb_data_o, e.data);
      end
    end
    if (dmem_req_o && dmem_gnt_i) begin
      if (exp_req.size() == 0) check("req_unexpected", 32'(dmem_req_o), 0);
      else begin
        r = exp_req.pop_front();
        check("req_we", 32'(dmem_we_o), 32'(r.we));
        check("req_addr", dmem_addr_o, r.addr);
        if (r.we) begin
          check("req_be", 32'(dmem_be_o), 32'(r.be));
          check("req_wdata", dmem_wdata_o, r.wdata);
        end
      end
    end
    if (bus_err_o) bus_err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [10:0] rd,
                      input logic [31:0] rdd, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    while (!ready_mem_2_exe_o && n < 100) begin
      tick();
      n++;
    end
    if (!ready_mem_2_exe_o) check("ready_timeout", 32'(ready_mem_2_exe_o), 1);
    valid_exe_2_mem_i   = 1'b1;
    opcode_exe_2_mem_i  = {22'($urandom()), f3, opc};
    rd_exe_2_mem_i      = rd;
    rd_data_exe_2_mem_i = rdd;
    mem_address_i       = addr;
    mem_data_i          = data;
    tick();
    valid_exe_2_mem_i   = 1'b0;
  endtask

  task automatic grant(input int gnt_wait, input logic [31:0] exp_addr);
    for (int i = 0; i < gnt_wait; i++) begin
      check("req_held", 32'(dmem_req_o), 1);
      check("ready_low", 32'(ready_mem_2_exe_o), 0);
      check("addr_stable", dmem_addr_o, exp_addr);
      tick();
    end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
  endtask

  task automatic respond(input int rsp_wait, input logic [31:0] rdata);
    repeat (rsp_wait) tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = $urandom();
  endtask

  task automatic push_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    req_t r;
    r.we    = we;
    r.be    = model_be(f3, addr[1:0]);
    r.addr  = {addr[31:2], 2'b00};
    r.wdata = model_wdata(f3, data);
    exp_req.push_back(r);
  endtask

  task automatic mem_access(input logic is_store, input logic [2:0] f3, input logic [10:0] rd,
                            input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                            input int gnt_wait, input int rsp_wait);
    push_req(is_store, f3, addr, data);
    if (!is_store && rd[4:0] != 5'd0) exp_wb.push_back('{rd, model_load(f3, addr[1:0], rdata)});
    send(is_store ? OPC_STORE : OPC_LOAD, f3, rd, $urandom(), addr, data);
    grant(gnt_wait, {addr[31:2], 2'b00});
    if (!is_store) respond(rsp_wait, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind, n;

    // Reset with a stray response on the bus.
    rstl = 1'b0;
    dmem_rvalid_i = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(ready_mem_2_exe_o), 1);
    check("rst_req", 32'(dmem_req_o), 0);
    check("rst_we", 32'(dmem_we_o), 0);
    check("rst_be", 32'(dmem_be_o), 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_wdata", dmem_wdata_o, 0);
    check("rst_wb_valid", 32'(wb_valid_o), 0);
    check("rst_wb_rd", 32'(wb_rd_o), 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_bus_err", 32'(bus_err_o), 0);
    rstl = 1'b1;
    tick();
    dmem_rvalid_i = 1'b0;
    tick();

    // Non-memory op: writeback the next cycle.
    exp_wb.push_back('{11'd5, 32'h1234_5678});
    send(OPC_ALU, 3'b000, 11'd5, 32'h1234_5678, $urandom(), $urandom());
    check("nm_wb_valid", 32'(wb_valid_o), 1);
    check("nm_wb_rd", 32'(wb_rd_o), 5);
    check("nm_wb_data", wb_data_o, 32'h1234_5678);
    check("nm_ready", 32'(ready_mem_2_exe_o), 1);

    // Back-to-back non-memory ops; rd[4:0]==0 suppresses the pulse regardless of rd[10:5].
    exp_wb.push_back('{11'h405, 32'hCAFE_0001});
    send(OPC_ALU, 3'b000, 11'h405, 32'hCAFE_0001, 0, 0);
    send(OPC_ALU, 3'b000, 11'h400, 32'hDEAD_0002, 0, 0);
    exp_wb.push_back('{11'd9, 32'hCAFE_0003});
    send(OPC_ALU, 3'b111, 11'd9, 32'hCAFE_0003, 0, 0);
    tick();

    // SB to byte 3: lane 3 enable, replicated data, no writeback.
    exp_req.push_back('{1'b1, 4'b1000, 32'h100, 32'hABAB_ABAB});
    send(OPC_STORE, 3'b000, 11'd4, 0, 32'h103, 32'h0000_00AB);
    check("sb_req", 32'(dmem_req_o), 1);
    check("sb_ready", 32'(ready_mem_2_exe_o), 0);
    check("sb_we", 32'(dmem_we_o), 1);
    check("sb_addr", dmem_addr_o, 32'h100);
    check("sb_be", 32'(dmem_be_o), 32'h8);
    check("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("sb_ready_after", 32'(ready_mem_2_exe_o), 1);
    check("sb_req_after", 32'(dmem_req_o), 0);

    // LB / LBU sign and zero extension, minimum latency.
    exp_req.push_back('{1'b0, 4'b0000, 32'h100, 32'h0});
    exp_wb.push_back('{11'd3, 32'hFFFF_FF80});
    send(OPC_LOAD, 3'b000, 11'd3, 0, 32'h102, 0);
    grant(0, 32'h100);
    respond(0, 32'h0080_0000);
    check("lb_wb_latency", 32'(wb_valid_o), 1);
    exp_req.push_back('{1'b0, 4'b0000, 32'h100, 32'h0});
    exp_wb.push_back('{11'd3, 32'h0000_0080});
    send(OPC_LOAD, 3'b100, 11'd3, 0, 32'h102, 0);
    grant(0, 32'h100);
    respond(0, 32'h0080_0000);

    // LW with grant held off for 3 cycles.
    mem_access(1'b0, 3'b010, 11'd12, 32'h208, 0, 32'h8765_4321, 3, 2);
    check("lw_wb_after_rvalid", 32'(wb_valid_o), 1);

    // Flush while waiting for the response: data discarded.
    exp_req.push_back('{1'b0, 4'b0000, 32'h300, 32'h0});
    send(OPC_LOAD, 3'b010, 11'd6, 0, 32'h300, 0);
    grant(0, 32'h300);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    respond(0, 32'h1111_2222);
    check("flush_wait_ready", 32'(ready_mem_2_exe_o), 1);
    exp_wb.push_back('{11'd8, 32'h0BAD_F00D});
    send(OPC_ALU, 3'b000, 11'd8, 32'h0BAD_F00D, 0, 0);
    check("flush_next_accept", 32'(wb_valid_o), 1);

    // Flush in REQ without grant: request withdrawn.
    send(OPC_STORE, 3'b010, 11'd0, 0, 32'h400, 32'h5555_AAAA);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_req_drop", 32'(dmem_req_o), 0);
    check("flush_req_ready", 32'(ready_mem_2_exe_o), 1);

    // Flush coincident with grant: store still written, load response discarded.
    push_req(1'b1, 3'b001, 32'h442, 32'h0000_BEEF);
    send(OPC_STORE, 3'b001, 11'd0, 0, 32'h442, 32'h0000_BEEF);
    flush_i = 1'b1;
    dmem_gnt_i = 1'b1;
    tick();
    flush_i = 1'b0;
    dmem_gnt_i = 1'b0;
    check("fg_store_ready", 32'(ready_mem_2_exe_o), 1);
    push_req(1'b0, 3'b010, 32'h480, 0);
    send(OPC_LOAD, 3'b010, 11'd7, 0, 32'h480, 0);
    flush_i = 1'b1;
    dmem_gnt_i = 1'b1;
    tick();
    flush_i = 1'b0;
    dmem_gnt_i = 1'b0;
    check("fg_load_wait", 32'(ready_mem_2_exe_o), 0);
    respond(1, 32'h7777_7777);
    check("fg_load_ready", 32'(ready_mem_2_exe_o), 1);

    // Response timeout.
    push_req(1'b0, 3'b010, 32'h500, 0);
    send(OPC_LOAD, 3'b010, 11'd10, 0, 32'h500, 0);
    grant(0, 32'h500);
    n = 1;
    while (!bus_err_o && n < TO + 10) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TO + 1);
    check("timeout_bus_err", 32'(bus_err_o), 1);
    check("timeout_ready", 32'(ready_mem_2_exe_o), 1);
    tick();
    check("bus_err_pulse", 32'(bus_err_o), 0);

    // Reset while a load is outstanding: the late response is ignored.
    push_req(1'b0, 3'b010, 32'h600, 0);
    send(OPC_LOAD, 3'b010, 11'd11, 0, 32'h600, 0);
    grant(0, 32'h600);
    tick();
    rstl = 1'b0;
    tick();
    rstl = 1'b1;
    check("midrst_ready", 32'(ready_mem_2_exe_o), 1);
    respond(0, 32'h9999_9999);
    tick();

`ifdef MISALIGN_TRAP_EN
    send(OPC_LOAD, 3'b010, 11'd5, 0, 32'h102, 0);
    check("mis_pulse", 32'(misalign_o), 1);
    check("mis_addr", misalign_addr_o, 32'h102);
    check("mis_no_req", 32'(dmem_req_o), 0);
    check("mis_no_wb", 32'(wb_valid_o), 0);
    tick();
    check("mis_pulse_end", 32'(misalign_o), 0);
    check("mis_still_no_req", 32'(dmem_req_o), 0);
`else
    // Offending low bits are ignored for half/word accesses.
    mem_access(1'b1, 3'b001, 11'd0, 32'h703, 32'h0000_1234, 0, 0, 0);
    mem_access(1'b0, 3'b001, 11'd13, 32'h701, 0, 32'h8001_7002, 0, 1);
    mem_access(1'b0, 3'b010, 11'd14, 32'h707, 0, 32'hA5A5_0F0F, 1, 0);
`endif

    // Mixed random traffic.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom();
      if (kind == 0) begin
        logic [10:0] rd = 11'($urandom());
        logic [31:0] d  = $urandom();
        if (rd[4:0] != 5'd0) exp_wb.push_back('{rd, d});
        send(OPC_ALU, 3'($urandom()), rd, d, addr, $urandom());
      end else begin
        f3 = (kind == 1) ? ld_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
`ifdef MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1]) addr[1:0] = 2'b00;
`endif
        mem_access(kind == 2, f3, 11'($urandom()), addr, $urandom(), $urandom(),
                   $urandom_range(0, 2), $urandom_range(0, 2));
      end
    end

    repeat (3) tick();
    check("wb_queue_empty", 32'(exp_wb.size()), 0);
    check("req_queue_empty", 32'(exp_req.size()), 0);
    check("bus_err_total", 32'(bus_err_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
